// File: rtl/prewish_button_poller.sv
// prewish_button_poller
// Initiator side of the prewish strobe/data status handshake. A free-running
// launch divider periodically issues a one-cycle request strobe. The block then
// waits a bounded time for the responder's answer strobe and captures the
// returned button byte. Each capture produces one-cycle press/release masks,
// a level copy of the buttons and a toggling heartbeat. A missing answer sets
// a sticky timeout flag instead of stalling the poller.

module prewish_button_poller #(
  parameter int unsigned POLL_DIV = 1000,  // cycles from launch to launch, >= 8
  parameter int unsigned TIMEOUT  = 16     // max cycles spent waiting, >= 4
) (
  input  logic       CLK_I,
  input  logic       RST_N_I,
  input  logic       i_enable,
  input  logic [7:0] i_mask,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  output logic [7:0] o_buttons,
  output logic [7:0] o_pressed,
  output logic [7:0] o_released,
  output logic       o_valid,
  output logic       o_timeout,
  output logic       o_alive
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int unsigned       WAIT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
  localparam logic [31:0]       CNT_RELOAD = 32'(POLL_DIV - 1);

  logic [1:0]        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        new_q, new_d;
  logic              stb_q, stb_d;
  logic [7:0]        dat_q, dat_d;
  logic [7:0]        buttons_q, buttons_d;
  logic [7:0]        pressed_q, pressed_d;
  logic [7:0]        released_q, released_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;
  logic              alive_q, alive_d;

  // Next-state logic: poll sequencing, launch divider and capture bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    new_d      = new_q;
    stb_d      = 1'b0;
    dat_d      = dat_q;
    buttons_d  = buttons_q;
    pressed_d  = 8'h00;
    released_d = 8'h00;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;
    alive_d    = alive_q;

    // The launch period keeps running during a transaction. Once it expires it
    // parks at zero so the next launch fires as soon as the poller is idle again.
    if (state_q != ST_IDLE && cnt_q != 32'd0) begin
      cnt_d = cnt_q - 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          if (cnt_q == 32'd0) begin
            cnt_d   = CNT_RELOAD;
            state_d = ST_REQ;
            stb_d   = 1'b1;
            dat_d   = i_mask;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end else begin
          cnt_d = CNT_RELOAD;
        end
      end

      ST_REQ: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        wait_d = wait_q + WAIT_ONE;
        // An answer in the expiry cycle still counts, so it is tested first.
        if (STB_I) begin
          new_d   = DAT_I;
          state_d = ST_DONE;
        end else if (wait_d == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_DONE: begin
        pressed_d  = new_q & ~buttons_q;
        released_d = ~new_q & buttons_q;
        buttons_d  = new_q;
        valid_d    = 1'b1;
        timeout_d  = 1'b0;
        alive_d    = ~alive_q;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset returns everything to a quiet idle.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_RELOAD;
      wait_q     <= '0;
      new_q      <= 8'h00;
      stb_q      <= 1'b0;
      dat_q      <= 8'h00;
      buttons_q  <= 8'h00;
      pressed_q  <= 8'h00;
      released_q <= 8'h00;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values of
      // the previous cycle regardless of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      new_q      <= new_d;
      stb_q      <= stb_d;
      dat_q      <= dat_d;
      buttons_q  <= buttons_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      alive_q    <= alive_d;
    end
  end

  assign STB_O      = stb_q;
  assign DAT_O      = dat_q;
  assign o_buttons  = buttons_q;
  assign o_pressed  = pressed_q;
  assign o_released = released_q;
  assign o_valid    = valid_q;
  assign o_timeout  = timeout_q;
  assign o_alive    = alive_q;

endmodule
